array_stream_reader: RTL and testbench

- Reader side of a packed 2-D array store `arr[ROWS][COLS]` kept in a single-port synchronous RAM; the writer side fills it.
- On `start`, walks every element, issues RAM reads and streams elements out on a valid/ready interface, each tagged with its row/column indices.
- Sits between the array RAM and downstream consumers; owns RAM read arbitration and output backpressure.

---
 rtl/array_stream_reader.sv | 222 ++++++++++++++++++++++
 tb/tb_array_stream_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/array_stream_reader.sv
// array_stream_reader: reader side of a ROWS x COLS array held in a single-port
// synchronous RAM. On start it walks every element, issues RAM reads under a
// 2-credit limit and streams the elements out on a valid/ready interface,
// tagged with their row/column indices.
//
// Optional feature macro: ARRAY_STREAM_READER_COL_MAJOR_EN
//   defined   -> column-major traversal (row advances fastest)
//   undefined -> row-major traversal (col advances fastest)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        begin a traversal when idle / flush the current one
//   busy, done          traversal in progress / one-cycle completion pulse
//   mem_rd_en, mem_addr RAM read strobe and address (row*COLS + col)
//   mem_rd_data         RAM read data, valid the cycle after mem_rd_en
//   out_valid/out_ready output handshake
//   out_data, out_row, out_col, out_last  element payload and tag

module array_stream_reader #(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned COLS   = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned ADDR_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              out_last
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t             state;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row_nxt;
  logic [COL_W-1:0]   col_nxt;
  logic               at_end;

  // Tag of the read whose data is on mem_rd_data this cycle
  logic               rd_vld;
  logic [ROW_W-1:0]   tag_row;
  logic [COL_W-1:0]   tag_col;
  logic               tag_last;

  // Second FIFO entry; the first entry is the out_* register set itself
  logic [DATA_W-1:0]  skid_data;
  logic [ROW_W-1:0]   skid_row;
  logic [COL_W-1:0]   skid_col;
  logic               skid_last;
  logic [1:0]         count;

  logic               push;
  logic               pop;
  logic [1:0]         occ_next;
  logic               issue;

  assign push     = rd_vld;
  assign pop      = out_valid && out_ready;
  // FIFO occupancy once this cycle's push/pop settle; the RAM read arriving
  // now is counted through push, so occ_next covers every outstanding element.
  assign occ_next = count + 2'(push) - 2'(pop);
  // Read strobe is decided in the issuing cycle so that a full-rate stream
  // fits in two credits.
  assign issue     = (state == ISSUE) && (occ_next < 2'd2) && !abort;
  assign mem_rd_en = issue;

  assign at_end = (row == ROW_W'(ROWS - 1)) && (col == COL_W'(COLS - 1));

  // Traversal order: next index after the current one, wrapping at the end
  always_comb begin
    row_nxt = row;
    col_nxt = col;
`ifdef ARRAY_STREAM_READER_COL_MAJOR_EN
    if (row == ROW_W'(ROWS - 1)) begin
      row_nxt = '0;
      col_nxt = (col == COL_W'(COLS - 1)) ? '0 : col + COL_W'(1);
    end else begin
      row_nxt = row + ROW_W'(1);
    end
`else
    if (col == COL_W'(COLS - 1)) begin
      col_nxt = '0;
      row_nxt = (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
    end else begin
      col_nxt = col + COL_W'(1);
    end
`endif
  end

  // Control FSM, index counters, read-tag pipeline and output FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      row       <= '0;
      col       <= '0;
      mem_addr  <= '0;
      rd_vld    <= 1'b0;
      tag_row   <= '0;
      tag_col   <= '0;
      tag_last  <= 1'b0;
      skid_data <= '0;
      skid_row  <= '0;
      skid_col  <= '0;
      skid_last <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else begin
      done   <= 1'b0;
      rd_vld <= issue;

      if (issue) begin
        row      <= row_nxt;
        col      <= col_nxt;
        mem_addr <= ADDR_W'(row_nxt * COLS + col_nxt);
        tag_row  <= row;
        tag_col  <= col;
        tag_last <= at_end;
      end

      // FIFO: head lives in out_*, overflow goes to the skid entry
      case (count)
        2'd0: begin
          if (push) begin
            out_data <= mem_rd_data;
            out_row  <= tag_row;
            out_col  <= tag_col;
            out_last <= tag_last;
          end
        end
        2'd1: begin
          if (push && pop) begin
            out_data <= mem_rd_data;
            out_row  <= tag_row;
            out_col  <= tag_col;
            out_last <= tag_last;
          end else if (push) begin
            skid_data <= mem_rd_data;
            skid_row  <= tag_row;
            skid_col  <= tag_col;
            skid_last <= tag_last;
          end
        end
        default: begin
          if (pop) begin
            out_data <= skid_data;
            out_row  <= skid_row;
            out_col  <= skid_col;
            out_last <= skid_last;
            if (push) begin
              skid_data <= mem_rd_data;
              skid_row  <= tag_row;
              skid_col  <= tag_col;
              skid_last <= tag_last;
            end
          end
        end
      endcase
      count     <= occ_next;
      out_valid <= (occ_next != 2'd0);

      case (state)
        IDLE: begin
          if (start && !abort) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            row      <= '0;
            col      <= '0;
            mem_addr <= '0;
          end
        end
        ISSUE: begin
          if (issue && at_end) state <= DRAIN;
        end
        DRAIN: begin
          // Done pulses in the cycle right after the final handshake
          if (occ_next == 2'd0 && !rd_vld) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
      endcase

      // Abort flushes everything, including a read whose data is still due
      if (abort && state != IDLE) begin
        state     <= IDLE;
        busy      <= 1'b0;
        done      <= 1'b0;
        row       <= '0;
        col       <= '0;
        mem_addr  <= '0;
        rd_vld    <= 1'b0;
        count     <= '0;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_array_stream_reader.sv
// Testbench for array_stream_reader: synchronous RAM model with mem[a] = a,
// table of full-traversal scenarios plus hand-written abort/reset sequences.
module tb_array_stream_reader;

`ifdef ARRAY_STREAM_READER_COL_MAJOR_EN
  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 3;
`else
  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 32;
`endif
  localparam int unsigned DATA_W = 32;
  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [RW-1:0]     out_row;
  logic [CW-1:0]     out_col;
  logic              out_last;

  int n_tests = 0;
  int n_fail  = 0;

  array_stream_reader #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM preloaded with mem[a] = a
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= DATA_W'(mem_addr);
  end

  typedef struct {
    int    mode;        // 0: ready=1, 1: ready 1-0-0-1, 2: LFSR ready, 3: ready=1 + start while busy
    string name;
    int    exp_beats;
    int    exp_dones;
    int    exp_first;   // cycles from the start-sampling edge to first out_valid
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] act_pack();
    return 64'({out_valid, out_data, out_row, out_col, out_last});
  endfunction

  // Expected payload of the k-th beat in traversal order
  function automatic logic [63:0] exp_pack(input int k);
    int r;
    int c;
`ifdef ARRAY_STREAM_READER_COL_MAJOR_EN
    r = k % ROWS;
    c = k / ROWS;
`else
    r = k / COLS;
    c = k % COLS;
`endif
    return 64'({1'b1, DATA_W'(r * COLS + c), RW'(r), CW'(c), (k == N - 1)});
  endfunction

  task automatic run_stream(input vec_t v);
    int beats = 0, dones = 0, first_valid = -1, last_hs = -1, done_cyc = -1;
    int issued = 0, max_out = 0, outst;
    logic prev_stall = 1'b0;
    logic [63:0] prev_pack = '0;
    logic [15:0] lfsr = 16'hACE1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (prev_stall) check({v.name, "_hold"}, act_pack(), prev_pack);
      if (out_valid && first_valid < 0) first_valid = c;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
      case (v.mode)
        1: out_ready = (c % 4 == 0) || (c % 4 == 3);
        2: begin
          lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
          out_ready = lfsr[0];
        end
        default: out_ready = 1'b1;
      endcase
      start = (v.mode == 3) && (c == 5 || c == 100);
      #1;
      if (mem_rd_en) issued++;
      if (out_valid && out_ready) begin
        if (beats < N) check({v.name, "_beat"}, act_pack(), exp_pack(beats));
        beats++;
        last_hs = c;
      end
      prev_stall = out_valid && !out_ready;
      prev_pack  = act_pack();
      @(posedge clk); #1;
      outst = issued - beats;
      if (outst > max_out) max_out = outst;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check({v.name, "_beats"}, 64'(beats), 64'(v.exp_beats));
    check({v.name, "_dones"}, 64'(dones), 64'(v.exp_dones));
    check({v.name, "_first_valid"}, 64'(first_valid), 64'(v.exp_first));
    check({v.name, "_done_latency"}, 64'(done_cyc), 64'(last_hs + 1));
    check({v.name, "_credit_le2"}, 64'(max_out <= 2), 64'(1));
    if (v.mode == 0) check({v.name, "_full_rate"}, 64'(last_hs), 64'(N + 1));
  endtask

  initial begin
    int hs;
    int target;
    logic dseen;
    vec_t fresh;

    vecs[0] = '{mode: 0, name: "ready_high",   exp_beats: N, exp_dones: 1, exp_first: 2};
    vecs[1] = '{mode: 1, name: "ready_1001",   exp_beats: N, exp_dones: 1, exp_first: 2};
    vecs[2] = '{mode: 2, name: "ready_lfsr",   exp_beats: N, exp_dones: 1, exp_first: 2};
    vecs[3] = '{mode: 3, name: "start_busy",   exp_beats: N, exp_dones: 1, exp_first: 2};
    fresh   = vecs[0];

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_done",      64'(done),      64'(0));
    check("rst_mem_rd_en", 64'(mem_rd_en), 64'(0));
    check("rst_mem_addr",  64'(mem_addr),  64'(0));
    check("rst_outputs",   act_pack(),     64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // start and abort together while idle: nothing starts
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", 64'(busy), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    check("idle_abort_valid", 64'(out_valid), 64'(0));
    check("idle_abort_busy2", 64'(busy), 64'(0));

    for (int i = 0; i < 4; i++) run_stream(vecs[i]);

    // Abort after 10 handshakes while the consumer is stalled
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < 200 && hs < 10; c++) begin
      if (out_valid && out_ready) hs++;
      @(posedge clk); #1;
    end
    check("abort_hs_reached", 64'(hs), 64'(10));
    out_ready = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", 64'(out_valid), 64'(0));
    check("abort_busy",  64'(busy),      64'(0));
    dseen = done;
    repeat (4) begin
      @(posedge clk); #1;
      dseen = dseen | done;
    end
    check("abort_no_done", 64'(dseen), 64'(0));
    fresh.name = "after_abort";
    run_stream(fresh);

    // Asynchronous reset in the middle of a traversal
    target = (N > 100) ? 100 : N / 2;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < 400 && hs < target; c++) begin
      if (out_valid && out_ready) hs++;
      @(posedge clk); #1;
    end
    check("midrst_reached", 64'(hs), 64'(target));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",      64'(busy),      64'(0));
    check("midrst_mem_rd_en", 64'(mem_rd_en), 64'(0));
    check("midrst_mem_addr",  64'(mem_addr),  64'(0));
    check("midrst_outputs",   act_pack(),     64'(0));
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fresh.name = "after_reset";
    run_stream(fresh);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
